// File: rtl/floating_point_div_seq_pkg.sv
// Shared types and constants for the iterative floating-point divider.
// Round-mode encoding and exception bit positions match the FMA.
package fp_div_pkg;

  typedef enum logic [2:0] {IDLE, PREP, DIV, ROUND, DONE} state_t;

  localparam int FP_EXP_W   = 8;
  localparam int FP_FRAC_W  = 23;
  localparam int BIAS       = (1 << (FP_EXP_W - 1)) - 1;
  localparam int ITER_COUNT = FP_FRAC_W + 4;
  localparam int CNT_W      = $clog2(ITER_COUNT + 1);

  localparam logic [1:0] FP_ROUND_RNE  = 2'd0;
  localparam logic [1:0] FP_ROUND_RTZ  = 2'd1;
  localparam logic [1:0] FP_ROUND_DOWN = 2'd2;
  localparam logic [1:0] FP_ROUND_UP   = 2'd3;

  localparam int FP_INVALID   = 4;
  localparam int FP_DIVBYZERO = 3;
  localparam int FP_OVERFLOW  = 2;
  localparam int FP_UNDERFLOW = 1;
  localparam int FP_INEXACT   = 0;

  // Increment decision from {lsb, guard, round|sticky}
  function automatic logic round_inc(input logic [1:0] mode, input logic sign,
                                     input logic lsb, input logic guard, input logic rs);
    case (mode)
      FP_ROUND_RNE:  round_inc = guard & (rs | lsb);
      FP_ROUND_RTZ:  round_inc = 1'b0;
      FP_ROUND_DOWN: round_inc = sign & (guard | rs);
      default:       round_inc = ~sign & (guard | rs);
    endcase
  endfunction

endpackage

// File: rtl/floating_point_div_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
interface floating_point_div_seq_if #(
  parameter int exp_width  = 8,
  parameter int frac_width = 23
);
  localparam int W = exp_width + frac_width + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_num;
  logic [W-1:0] op_den;
  logic [1:0]   round_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   exception;

  modport master (output in_valid, op_num, op_den, round_mode, out_ready,
                  input  in_ready, out_valid, result, exception);
  modport slave  (input  in_valid, op_num, op_den, round_mode, out_ready,
                  output in_ready, out_valid, result, exception);
endinterface

// File: rtl/floating_point_div_seq.sv
// Iterative IEEE-754 divider: restoring division, one quotient bit per clock,
// fixed latency for every operand class including specials.
module floating_point_div_seq
  import fp_div_pkg::*;
#(
  parameter int exp_width  = FP_EXP_W,
  parameter int frac_width = FP_FRAC_W
) (
  input logic clk,
  input logic rst_n,
  floating_point_div_seq_if.slave bus
);
  localparam int W     = exp_width + frac_width + 1;
  localparam int MW    = frac_width + 1;
  localparam int QW    = frac_width + 4;
  localparam int RW    = frac_width + 3;
  localparam int EW    = exp_width + 2;
  localparam int CW    = $clog2(QW + 1);
  localparam int LZW   = $clog2(MW + 1);
  localparam int EBIAS = (1 << (exp_width - 1)) - 1;
  localparam int EMAX  = (1 << exp_width) - 1;

  typedef logic signed [EW-1:0] sexp_t;

  state_t        state;
  logic [W-1:0]  op_a, op_b;
  logic [1:0]    rmode;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rem;
  logic [MW-1:0] den;
  logic [QW-1:0] q;
  sexp_t         e;
  logic          sign;
  logic          spec_vld;
  logic [W-1:0]  spec_res;
  logic [4:0]    spec_exc;

  function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] m);
    lzc = '0;
    for (int i = 0; i < MW; i++)
      if (m[i]) lzc = LZW'(MW - 1 - i);
  endfunction

  // ---- unpack / classify / normalize (used in PREP) ----
  logic [exp_width-1:0]  ea, eb, ea_nz, eb_nz;
  logic [frac_width-1:0] fa, fb;
  logic a_zero, a_inf, a_nan, a_snan, b_zero, b_inf, b_nan, b_snan;
  logic [LZW-1:0] lza, lzb;
  logic [MW-1:0]  ma, mb;
  sexp_t          e_prep;
  logic           s_prep, p_vld;
  logic [W-1:0]   p_res;
  logic [4:0]     p_exc;

  always_comb begin
    ea = op_a[W-2:frac_width];  fa = op_a[frac_width-1:0];
    eb = op_b[W-2:frac_width];  fb = op_b[frac_width-1:0];
    a_nan  = (&ea) && (|fa);    b_nan  = (&eb) && (|fb);
    a_inf  = (&ea) && !(|fa);   b_inf  = (&eb) && !(|fb);
    a_zero = !(|ea) && !(|fa);  b_zero = !(|eb) && !(|fb);
    a_snan = a_nan && !fa[frac_width-1];
    b_snan = b_nan && !fb[frac_width-1];
    lza = lzc({|ea, fa});  ma = {|ea, fa} << lza;
    lzb = lzc({|eb, fb});  mb = {|eb, fb} << lzb;
    // denormals sit at exponent 1 before normalization
    ea_nz = (|ea) ? ea : exp_width'(1);
    eb_nz = (|eb) ? eb : exp_width'(1);
    e_prep = sexp_t'(ea_nz) - sexp_t'(lza) - sexp_t'(eb_nz) + sexp_t'(lzb) + sexp_t'(EBIAS);
    s_prep = op_a[W-1] ^ op_b[W-1];

    p_vld = 1'b1;
    p_exc = '0;
    p_res = {s_prep, {exp_width{1'b1}}, {frac_width{1'b0}}};
    if (a_nan || b_nan) begin
      p_res = (a_nan ? op_a : op_b) | (W'(1) << (frac_width - 1));
      p_exc[FP_INVALID] = a_snan | b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      p_res = {1'b1, {exp_width{1'b1}}, 1'b1, {(frac_width-1){1'b0}}};
      p_exc[FP_INVALID] = 1'b1;
    end else if (b_zero || a_inf) begin
      p_exc[FP_DIVBYZERO] = !a_inf;
    end else if (b_inf || a_zero) begin
      p_res = {s_prep, {(W-1){1'b0}}};
    end else begin
      p_vld = 1'b0;
    end
  end

  // ---- normalize, denormalize, round (used in ROUND) ----
  logic [QW-1:0] qn, qs, mask;
  sexp_t         en, sh_full, e_r, e_out;
  logic [CW-1:0] sh;
  logic          tiny, g, r, stk, inexact, inc, to_inf;
  logic [MW-1:0] mant;
  logic [MW:0]   sum;
  logic [W-1:0]  r_res;
  logic [4:0]    r_exc;

  always_comb begin
    qn      = q[QW-1] ? q : (q << 1);
    en      = q[QW-1] ? e : (e - sexp_t'(1));
    tiny    = (en <= 0);
    sh_full = sexp_t'(1) - en;
    sh      = '0;
    if (tiny) sh = (sh_full > sexp_t'(QW - 1)) ? CW'(QW - 1) : CW'(sh_full);
    mask    = ~({QW{1'b1}} << sh);
    qs      = qn >> sh;
    stk     = (|rem) | (|(qn & mask)) | qs[0];
    g       = qs[2];
    r       = qs[1];
    mant    = qs[QW-1:3];
    inexact = g | r | stk;
    inc     = round_inc(rmode, sign, mant[0], g, r | stk);
    sum     = {1'b0, mant} + (MW+1)'(inc);
    // a carry out of a denormal lands on the hidden bit, i.e. min normal
    e_r     = tiny ? sexp_t'(1) : en;
    e_out   = sum[MW] ? (e_r + sexp_t'(1)) : (sum[MW-1] ? e_r : '0);
    to_inf  = (rmode == FP_ROUND_RNE) || (rmode == FP_ROUND_UP && !sign) ||
              (rmode == FP_ROUND_DOWN && sign);
    r_exc   = '0;
    if (e_out >= sexp_t'(EMAX)) begin
      r_res = to_inf ? {sign, {exp_width{1'b1}}, {frac_width{1'b0}}}
                     : {sign, {(exp_width-1){1'b1}}, 1'b0, {frac_width{1'b1}}};
      r_exc[FP_OVERFLOW] = 1'b1;
      r_exc[FP_INEXACT]  = 1'b1;
    end else begin
      r_res = {sign, e_out[exp_width-1:0], sum[frac_width-1:0]};
      r_exc[FP_INEXACT]   = inexact;
      r_exc[FP_UNDERFLOW] = tiny & inexact;
    end
    if (spec_vld) begin
      r_res = spec_res;
      r_exc = spec_exc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.exception <= '0;
      op_a <= '0;  op_b <= '0;  rmode <= '0;
      cnt  <= '0;  rem  <= '0;  den   <= '0;  q <= '0;
      e    <= '0;  sign <= 1'b0;
      spec_vld <= 1'b0;  spec_res <= '0;  spec_exc <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid && bus.in_ready) begin
          op_a         <= bus.op_num;
          op_b         <= bus.op_den;
          rmode        <= bus.round_mode;
          bus.in_ready <= 1'b0;
          state        <= PREP;
        end
        PREP: begin
          rem      <= RW'(ma);
          den      <= mb;
          e        <= e_prep;
          sign     <= s_prep;
          spec_vld <= p_vld;
          spec_res <= p_res;
          spec_exc <= p_exc;
          q        <= '0;
          cnt      <= CW'(QW - 1);
          state    <= DIV;
        end
        DIV: begin
          if (rem >= RW'(den)) begin
            q   <= {q[QW-2:0], 1'b1};
            rem <= (rem - RW'(den)) << 1;
          end else begin
            q   <= {q[QW-2:0], 1'b0};
            rem <= rem << 1;
          end
          if (cnt == '0) state <= ROUND;
          else           cnt   <= cnt - CW'(1);
        end
        ROUND: begin
          bus.result    <= r_res;
          bus.exception <= r_exc;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_floating_point_div_seq.sv
// Scoreboard bench for the sequential divider: driver pushes expected results,
// a negedge monitor checks latency and result/flags at each handshake.
`timescale 1ns/1ps
module tb_floating_point_div_seq;
  import fp_div_pkg::*;

  localparam logic [4:0] X_NX = 5'b1 << FP_INEXACT;
  localparam logic [4:0] X_UF = 5'b1 << FP_UNDERFLOW;
  localparam logic [4:0] X_OF = 5'b1 << FP_OVERFLOW;
  localparam logic [4:0] X_DZ = 5'b1 << FP_DIVBYZERO;
  localparam logic [4:0] X_NV = 5'b1 << FP_INVALID;
  localparam int LAT = 29;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  floating_point_div_seq_if #(.exp_width(8), .frac_width(23)) bus ();
  floating_point_div_seq #(.exp_width(8), .frac_width(23)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [31:0] res; logic [4:0] exc; int acc; string name; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [1:0] rm;
                   logic [31:0] r; logic [4:0] x; string nm; } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) prev_ov = 1'b0;
    else begin
      if (bus.out_valid && !prev_ov) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid got result=%08h with nothing outstanding", bus.result);
        end else if ((cyc - sb[0].acc) != LAT || bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s latency got=%0d in_ready=%b want=%0d in_ready=0",
                   sb[0].name, cyc - sb[0].acc, bus.in_ready, LAT);
        end
      end
      if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (bus.result !== x.res || bus.exception !== x.exc) begin
          errors++;
          $display("FAIL %s got=%08h/%05b want=%08h/%05b",
                   x.name, bus.result, bus.exception, x.res, x.exc);
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  // called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                       input logic [31:0] er, input logic [4:0] ee, input string nm);
    int n = 0;
    exp_t x;
    bus.op_num = a;  bus.op_den = b;  bus.round_mode = rm;  bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL %s accept_timeout got in_ready=0 want 1", nm);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_num = 32'hDEADBEEF;  bus.op_den = 32'h12345678;  bus.round_mode = FP_ROUND_UP;
    x.res = er;  x.exc = ee;  x.acc = cyc;  x.name = nm;
    sb.push_back(x);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s in_ready_after_accept got=%b want=0", nm, bus.in_ready);
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain_timeout got outstanding=%0d want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                     input logic [31:0] r, input logic [4:0] x, input string nm);
    vec_t v;
    v.a = a; v.b = b; v.rm = rm; v.r = r; v.x = x; v.nm = nm;
    vt.push_back(v);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;  bus.op_num = '0;  bus.op_den = '0;
    bus.round_mode = FP_ROUND_RNE;  bus.out_ready = 1'b1;

    add(32'h40C00000, 32'h40000000, FP_ROUND_RNE,  32'h40400000, 5'b0,        "six_by_two");
    add(32'h3F800000, 32'h40400000, FP_ROUND_RNE,  32'h3EAAAAAB, X_NX,        "third_rne");
    add(32'h3F800000, 32'h40400000, FP_ROUND_RTZ,  32'h3EAAAAAA, X_NX,        "third_rtz");
    add(32'h3F800000, 32'h40400000, FP_ROUND_UP,   32'h3EAAAAAB, X_NX,        "third_up");
    add(32'h3F800000, 32'h40400000, FP_ROUND_DOWN, 32'h3EAAAAAA, X_NX,        "third_down");
    add(32'h3F800000, 32'h00000000, FP_ROUND_RNE,  32'h7F800000, X_DZ,        "one_by_zero");
    add(32'h3F800000, 32'h80000000, FP_ROUND_RNE,  32'hFF800000, X_DZ,        "one_by_negzero");
    add(32'h00000000, 32'h00000000, FP_ROUND_RNE,  32'hFFC00000, X_NV,        "zero_by_zero");
    add(32'h7F800000, 32'h7F800000, FP_ROUND_RNE,  32'hFFC00000, X_NV,        "inf_by_inf");
    add(32'h7F800000, 32'h00000000, FP_ROUND_RNE,  32'h7F800000, 5'b0,        "inf_by_zero");
    add(32'hFF800000, 32'h40000000, FP_ROUND_RNE,  32'hFF800000, 5'b0,        "neginf_by_two");
    add(32'h40000000, 32'h7F800000, FP_ROUND_RNE,  32'h00000000, 5'b0,        "two_by_inf");
    add(32'h80000000, 32'h40400000, FP_ROUND_RNE,  32'h80000000, 5'b0,        "negzero_by_three");
    add(32'h7FA00000, 32'h3F800000, FP_ROUND_RNE,  32'h7FE00000, X_NV,        "snan_num");
    add(32'h7FC00001, 32'h7F800001, FP_ROUND_RNE,  32'h7FC00001, X_NV,        "qnan_num_snan_den");
    add(32'h7F7FFFFF, 32'h3F000000, FP_ROUND_RNE,  32'h7F800000, X_OF | X_NX, "ovf_rne");
    add(32'h7F7FFFFF, 32'h3F000000, FP_ROUND_RTZ,  32'h7F7FFFFF, X_OF | X_NX, "ovf_rtz");
    add(32'h7F7FFFFF, 32'h3F000000, FP_ROUND_UP,   32'h7F800000, X_OF | X_NX, "ovf_up");
    add(32'h7F7FFFFF, 32'h3F000000, FP_ROUND_DOWN, 32'h7F7FFFFF, X_OF | X_NX, "ovf_down");
    add(32'hFF7FFFFF, 32'h3F000000, FP_ROUND_UP,   32'hFF7FFFFF, X_OF | X_NX, "negovf_up");
    add(32'hFF7FFFFF, 32'h3F000000, FP_ROUND_DOWN, 32'hFF800000, X_OF | X_NX, "negovf_down");
    add(32'h00800000, 32'h40000000, FP_ROUND_RNE,  32'h00400000, 5'b0,        "exact_denorm");
    add(32'h00000001, 32'h40000000, FP_ROUND_RNE,  32'h00000000, X_UF | X_NX, "tiny_tie_rne");
    add(32'h00000001, 32'h40000000, FP_ROUND_UP,   32'h00000001, X_UF | X_NX, "tiny_up");

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.exception !== 5'h0) begin
      errors++;
      $display("FAIL reset_state got in_ready=%b out_valid=%b result=%08h exc=%05b want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.result, bus.exception);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      issue(vt[i].a, vt[i].b, vt[i].rm, vt[i].r, vt[i].x, vt[i].nm);
      drain(vt[i].nm);
    end

    // consumer stall: result must hold while out_ready is low
    bus.out_ready = 1'b0;
    issue(32'h40C00000, 32'h40000000, FP_ROUND_RNE, 32'h40400000, 5'b0, "stall");
    n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    repeat (10) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'h40400000 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold got valid=%b result=%08h in_ready=%b want 1 40400000 0",
                 bus.out_valid, bus.result, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    issue(32'h3F800000, 32'h40400000, FP_ROUND_RNE, 32'h3EAAAAAB, X_NX, "back_to_back");
    drain("back_to_back");

    // reset mid-division discards the operation
    issue(32'h40C00000, 32'h40000000, FP_ROUND_RNE, 32'h40400000, 5'b0, "rst_victim");
    repeat (13) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(32'h40C00000, 32'h40000000, FP_ROUND_RNE, 32'h40400000, 5'b0, "after_reset");
    drain("after_reset");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/floating_point_div_seq.md
Name: floating_point_div_seq

Overview:
- Iterative IEEE-754 floating-point divider: result = op_num / op_den, one quotient bit per clock.
- Companion to the combinational FMA in the FPU. Uses the same operand format, round-mode encoding and 5-bit exception vector.
- Sits behind a valid/ready handshake so the FPU issue logic can stall on it.

Parameters:
- exp_width, 8, exponent field width.
- frac_width, 23, stored fraction width. Total operand width = exp_width+frac_width+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  divider idle, can accept.
- op_num  in  exp_width+frac_width+1  dividend.
- op_den  in  exp_width+frac_width+1  divisor.
- round_mode  in  2  FP_ROUND_* encoding from FloatingPointConsts.svh.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  exp_width+frac_width+1  quotient.
- exception  out  5  flags at FP_INVALID/FP_DIVBYZERO/FP_OVERFLOW/FP_UNDERFLOW/FP_INEXACT bit positions.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, in_ready=1, out_valid=0, result=0, exception=0.
  - Reset mid-operation discards the operation; no result is produced.
- Accept when in_valid && in_ready. Operands and round_mode are captured on that edge. Later input changes have no effect.
- States: IDLE -> PREP -> DIV -> ROUND -> DONE -> IDLE.
  - IDLE: in_ready=1. Moves to PREP on accept.
  - PREP (1 cycle):
    - Unpack both operands and classify zero/inf/nan.
    - Normalize denormal mantissas to [1,2) with LeadingZerosCounter and adjust exponents.
    - Signed exponent, width exp_width+2: e = ea - eb + bias, with denormal exponent taken as 1 before adjustment.
    - sign = sa ^ sb.
    - Remainder initialised to the dividend mantissa.
  - DIV (frac_width+4 cycles, counter-driven):
    - Restoring step: if rem >= den then q bit = 1 and rem -= den; then rem <<= 1.
    - Quotient is in (0.5,2). If the MSB is 0, shift left by 1 and decrement e.
    - sticky = |rem at exit.
  - ROUND (1 cycle):
    - If e <= 0, right-shift the mantissa by 1-e with sticky OR-in. Shift is saturated at frac_width+3.
    - Feed {frac, guard, round|sticky} to FloatingPointRound.
    - A round carry increments the exponent. A denormal carry becomes the min normal.
  - DONE: out_valid=1, result/exception stable until out_ready. Moves to IDLE on out_ready.
- Latency: out_valid rises exactly frac_width+6 cycles after the accept edge (29 for fp32). Throughput is one operation per frac_width+7 cycles minimum.
- Special cases run the same fixed latency and override the datapath, in priority order:
  - Either NaN: quieted NaN, num first; INVALID only if signalling.
  - 0/0 or inf/inf: 0xFFC00000 (default -qNaN), INVALID.
  - x/0 with x finite non-zero: signed inf, DIVBYZERO.
  - inf/x: signed inf.
  - x/inf or 0/x: signed zero.
- Overflow handling, by round mode:
  - RNE: signed inf.
  - RTZ: signed MAX.
  - UP: +inf, or -MAX for negative results.
  - DOWN: -inf, or +MAX for positive results.
  - OVERFLOW and INEXACT are set in every mode.
- UNDERFLOW: set when the result is tiny (before rounding) and inexact.
- INEXACT: guard|round|sticky after any denormal shift.
- out_ready held high at DONE entry: out_valid is a 1-cycle pulse. in_ready rises the cycle after.

Decomposition:
- Package fp_div_pkg holds:
  - state enum (IDLE, PREP, DIV, ROUND, DONE);
  - localparams bias, iter_count = frac_width+4, counter width $clog2(iter_count+1).
- Reuse the existing LeadingZerosCounter and FloatingPointRound.
- No new sub-module is needed. The datapath is one module with a registered remainder, quotient and counter.

Test Plan:
- 0x40C00000 / 0x40000000, RNE -> 0x40400000 at cycle 29, exception=0; in_ready low for 29 cycles.
- 0x3F800000 / 0x40400000, RNE -> 0x3EAAAAAB with INEXACT. The same operation in RTZ -> 0x3EAAAAAA.
- 0x3F800000 / 0x00000000 -> 0x7F800000 with DIVBYZERO. 0x00000000 / 0x00000000 -> 0xFFC00000 with INVALID.
- 0x7F7FFFFF / 0x3F000000: RNE -> 0x7F800000, RTZ -> 0x7F7FFFFF, each with OVERFLOW|INEXACT. 0x00800000 / 0x40000000 -> 0x00400000, no flags (exact denormal).
- Hold out_ready=0 for 10 cycles -> result stable, in_ready=0. Then pulse out_ready -> in_ready=1 next cycle, and back-to-back accept works.
- Assert rst_n=0 at DIV iteration 12 -> out_valid=0 and in_ready=1 immediately. A fresh 6/2 after release -> 0x40400000 with normal latency.
